// File: rtl/mms_pkg.sv
// Shared MMU types and default sizing for the instruction TLB.
package mms_pkg;

   localparam int MXLEN        = 64;
   localparam int ITLB_ENTRIES = 32;
   localparam int ITLB_VPN_W   = 27;

   typedef logic [MXLEN-1:0] pte_t;

   // Entry record at the default geometry; storage is qualified by valid only.
   typedef struct packed {
      logic                  valid;
      logic [ITLB_VPN_W-1:0] vpn;
      pte_t                  pte;
   } itlb_entry_t;

endpackage

// File: rtl/itlb_cam_entry.sv
// One fully-associative ITLB slot: valid/VPN/PTE state, compare logic
// and a match-gated PTE output for the AND-OR read mux in the top level.
module itlb_cam_entry
   import mms_pkg::*;
#(
   parameter int VPN_W = ITLB_VPN_W,
   parameter int PTE_W = $bits(pte_t)
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic [VPN_W-1:0] lookup_vpn_i,
   input  logic             fill_we_i,
   input  logic [VPN_W-1:0] fill_vpn_i,
   input  logic [PTE_W-1:0] fill_pte_i,
   input  logic             flush_all_i,
   input  logic             flush_vpn_valid_i,
   input  logic [VPN_W-1:0] flush_vpn_i,
   output logic             valid_o,
   output logic             lookup_match_o,
   output logic             fill_match_o,
   output logic [PTE_W-1:0] pte_o
);

   logic             valid_q, valid_d;
   logic [VPN_W-1:0] vpn_q;
   logic [PTE_W-1:0] pte_q;

   always_comb begin
      valid_d = valid_q;
      if (flush_all_i) begin
         valid_d = 1'b0;
      end else if (flush_vpn_valid_i && (vpn_q == flush_vpn_i)) begin
         valid_d = 1'b0;
      end else if (fill_we_i) begin
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Payload is deliberately unreset; valid_q alone qualifies it.
   always_ff @(posedge clk_i) begin
      if (fill_we_i) begin
         vpn_q <= fill_vpn_i;
         pte_q <= fill_pte_i;
      end
   end

   assign valid_o        = valid_q;
   assign lookup_match_o = valid_q && (vpn_q == lookup_vpn_i);
   assign fill_match_o   = valid_q && (vpn_q == fill_vpn_i);
   assign pte_o          = lookup_match_o ? pte_q : '0;

endmodule

// File: rtl/itlb_cam_array.sv
// Fully-associative instruction TLB: per-entry CAM slots, victim selection
// (hit-in-place, lowest free, then round-robin) and registered lookup result.
module itlb_cam_array
   import mms_pkg::*;
#(
   parameter int ENTRIES = ITLB_ENTRIES,
   parameter int VPN_W   = ITLB_VPN_W,
   parameter int PTE_W   = $bits(pte_t),
   localparam int IDX_W  = $clog2(ENTRIES)
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             lookup_valid_i,
   input  logic [VPN_W-1:0] lookup_vpn_i,
   output logic             hit_o,
   output logic             miss_o,
   output logic [PTE_W-1:0] pte_o,
   output logic [IDX_W-1:0] hit_idx_o,
   input  logic             fill_valid_i,
   input  logic [VPN_W-1:0] fill_vpn_i,
   input  logic [PTE_W-1:0] fill_pte_i,
   input  logic             flush_all_i,
   input  logic             flush_vpn_valid_i,
   input  logic [VPN_W-1:0] flush_vpn_i,
   output logic             full_o
);

   logic [ENTRIES-1:0] valid_vec;
   logic [ENTRIES-1:0] match_vec;
   logic [ENTRIES-1:0] fill_match_vec;
   logic [ENTRIES-1:0] fill_we_vec;
   logic [PTE_W-1:0]   pte_gated [ENTRIES];

   logic [IDX_W-1:0]   rr_q, rr_d;
   logic               hit_q, hit_d;
   logic               miss_q, miss_d;
   logic [PTE_W-1:0]   pte_q, pte_d;
   logic [IDX_W-1:0]   idx_q, idx_d;

   genvar gi;
   generate
      for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
         itlb_cam_entry #(
            .VPN_W (VPN_W),
            .PTE_W (PTE_W)
         ) u_entry (
            .clk_i             (clk_i),
            .rstn_i            (rstn_i),
            .lookup_vpn_i      (lookup_vpn_i),
            .fill_we_i         (fill_we_vec[gi]),
            .fill_vpn_i        (fill_vpn_i),
            .fill_pte_i        (fill_pte_i),
            .flush_all_i       (flush_all_i),
            .flush_vpn_valid_i (flush_vpn_valid_i),
            .flush_vpn_i       (flush_vpn_i),
            .valid_o           (valid_vec[gi]),
            .lookup_match_o    (match_vec[gi]),
            .fill_match_o      (fill_match_vec[gi]),
            .pte_o             (pte_gated[gi])
         );
      end
   endgenerate

   assign full_o = &valid_vec;

   // Victim select; any flush in the same cycle drops the fill.
   logic               fill_go;
   logic               fill_in_place;
   logic [ENTRIES-1:0] free_oh;
   logic [ENTRIES-1:0] rr_oh;
   logic [ENTRIES-1:0] victim_oh;

   assign fill_go       = fill_valid_i && !flush_all_i && !flush_vpn_valid_i;
   assign fill_in_place = |fill_match_vec;
   assign free_oh       = ~valid_vec & (valid_vec + ENTRIES'(1));
   assign rr_oh         = ENTRIES'(1) << rr_q;

   always_comb begin
      victim_oh = rr_oh;
      if (fill_in_place) begin
         victim_oh = fill_match_vec;
      end else if (!full_o) begin
         victim_oh = free_oh;
      end
   end

   assign fill_we_vec = fill_go ? victim_oh : '0;

   always_comb begin
      rr_d = rr_q;
      if (flush_all_i) begin
         rr_d = '0;
      end else if (fill_go && !fill_in_place && full_o) begin
         rr_d = rr_q + IDX_W'(1);
      end
   end

   // AND-OR read mux: match_vec is one-hot, so OR-ing gated terms is exact.
   logic [PTE_W-1:0] pte_or;
   logic [IDX_W-1:0] idx_or;

   always_comb begin
      pte_or = '0;
      idx_or = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         pte_or = pte_or | pte_gated[i];
         idx_or = idx_or | (match_vec[i] ? IDX_W'(i) : IDX_W'(0));
      end
   end

   always_comb begin
      hit_d  = lookup_valid_i && (|match_vec);
      miss_d = lookup_valid_i && !(|match_vec);
      pte_d  = lookup_valid_i ? pte_or : '0;
      idx_d  = lookup_valid_i ? idx_or : '0;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rr_q   <= '0;
         hit_q  <= 1'b0;
         miss_q <= 1'b0;
         pte_q  <= '0;
         idx_q  <= '0;
      end else begin
         rr_q   <= rr_d;
         hit_q  <= hit_d;
         miss_q <= miss_d;
         pte_q  <= pte_d;
         idx_q  <= idx_d;
      end
   end

   assign hit_o     = hit_q;
   assign miss_o    = miss_q;
   assign pte_o     = pte_q;
   assign hit_idx_o = idx_q;

endmodule

// File: tb/tb_itlb_cam_array.sv
// Directed bench for itlb_cam_array at default geometry (32 entries).
module tb_itlb_cam_array;
   import mms_pkg::*;

   localparam int ENTRIES = 32;
   localparam int VPN_W   = 27;
   localparam int PTE_W   = 64;
   localparam int IDX_W   = 5;

   logic             clk_i = 1'b0;
   logic             rstn_i = 1'b0;
   logic             lookup_valid_i = 1'b0;
   logic [VPN_W-1:0] lookup_vpn_i = '0;
   logic             hit_o;
   logic             miss_o;
   logic [PTE_W-1:0] pte_o;
   logic [IDX_W-1:0] hit_idx_o;
   logic             fill_valid_i = 1'b0;
   logic [VPN_W-1:0] fill_vpn_i = '0;
   logic [PTE_W-1:0] fill_pte_i = '0;
   logic             flush_all_i = 1'b0;
   logic             flush_vpn_valid_i = 1'b0;
   logic [VPN_W-1:0] flush_vpn_i = '0;
   logic             full_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_i = ~clk_i;

   itlb_cam_array #(
      .ENTRIES (ENTRIES),
      .VPN_W   (VPN_W),
      .PTE_W   (PTE_W)
   ) dut (
      .clk_i             (clk_i),
      .rstn_i            (rstn_i),
      .lookup_valid_i    (lookup_valid_i),
      .lookup_vpn_i      (lookup_vpn_i),
      .hit_o             (hit_o),
      .miss_o            (miss_o),
      .pte_o             (pte_o),
      .hit_idx_o         (hit_idx_o),
      .fill_valid_i      (fill_valid_i),
      .fill_vpn_i        (fill_vpn_i),
      .fill_pte_i        (fill_pte_i),
      .flush_all_i       (flush_all_i),
      .flush_vpn_valid_i (flush_vpn_valid_i),
      .flush_vpn_i       (flush_vpn_i),
      .full_o            (full_o)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
   task automatic cycle(input logic lv, input logic [VPN_W-1:0] lvpn,
                        input logic fv, input logic [VPN_W-1:0] fvpn, input logic [PTE_W-1:0] fpte,
                        input logic fa, input logic fsv, input logic [VPN_W-1:0] fsvpn);
      lookup_valid_i    = lv;
      lookup_vpn_i      = lvpn;
      fill_valid_i      = fv;
      fill_vpn_i        = fvpn;
      fill_pte_i        = fpte;
      flush_all_i       = fa;
      flush_vpn_valid_i = fsv;
      flush_vpn_i       = fsvpn;
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      cycle(0, '0, 0, '0, '0, 0, 0, '0);
   endtask

   task automatic fill(input logic [VPN_W-1:0] vpn, input logic [PTE_W-1:0] pte);
      cycle(0, '0, 1, vpn, pte, 0, 0, '0);
   endtask

   task automatic lookup(input logic [VPN_W-1:0] vpn);
      cycle(1, vpn, 0, '0, '0, 0, 0, '0);
   endtask

   task automatic flush_all();
      cycle(0, '0, 0, '0, '0, 1, 0, '0);
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk_i);
      #1;
      check("rst hit", 64'(hit_o), 64'd0);
      check("rst miss", 64'(miss_o), 64'd0);
      check("rst pte", pte_o, 64'd0);
      check("rst idx", 64'(hit_idx_o), 64'd0);
      check("rst full", 64'(full_o), 64'd0);
      rstn_i = 1'b1;
      idle();

      // Basic fill and lookup
      fill(27'h100, 64'hA5);
      lookup(27'h100);
      check("basic hit", 64'(hit_o), 64'd1);
      check("basic miss", 64'(miss_o), 64'd0);
      check("basic pte", pte_o, 64'hA5);
      check("basic idx", 64'(hit_idx_o), 64'd0);
      idle();
      check("idle hit clr", 64'(hit_o), 64'd0);
      check("idle pte clr", pte_o, 64'd0);

      // Refill of a present VPN overwrites in place
      flush_all();
      fill(27'h100, 64'h1);
      fill(27'h100, 64'h2);
      lookup(27'h100);
      check("dup pte", pte_o, 64'h2);
      check("dup idx", 64'(hit_idx_o), 64'd0);
      fill(27'h300, 64'h3);
      lookup(27'h300);
      check("dup next idx", 64'(hit_idx_o), 64'd1);

      // Fill dropped when flush_all in the same cycle
      flush_all();
      cycle(0, '0, 1, 27'h200, 64'h77, 1, 0, '0);
      lookup(27'h200);
      check("flushfill miss", 64'(miss_o), 64'd1);
      check("flushfill hit", 64'(hit_o), 64'd0);
      check("flushfill pte", pte_o, 64'd0);

      // Lookup in fill cycle sees pre-fill contents
      cycle(1, 27'h400, 1, 27'h400, 64'h44, 0, 0, '0);
      check("nobypass miss", 64'(miss_o), 64'd1);
      lookup(27'h400);
      check("postfill pte", pte_o, 64'h44);

      // Selective flush
      flush_all();
      fill(27'h10, 64'h10);
      fill(27'h20, 64'h20);
      cycle(1, 27'h10, 0, '0, '0, 0, 1, 27'h10);
      check("preflush hit", 64'(hit_o), 64'd1);
      lookup(27'h10);
      check("selflush miss", 64'(miss_o), 64'd1);
      lookup(27'h20);
      check("selflush keep hit", 64'(hit_o), 64'd1);
      check("selflush keep idx", 64'(hit_idx_o), 64'd1);
      fill(27'h30, 64'h30);
      lookup(27'h30);
      check("refill idx0", 64'(hit_idx_o), 64'd0);

      // Full array and round-robin replacement
      flush_all();
      for (int i = 0; i < ENTRIES - 1; i++) fill(27'h1000 + 27'(i), 64'(i));
      check("full before last", 64'(full_o), 64'd0);
      fill(27'h101F, 64'h1F);
      check("full set", 64'(full_o), 64'd1);
      lookup(27'h101F);
      check("last idx", 64'(hit_idx_o), 64'd31);
      fill(27'h7FF, 64'hBEEF);
      lookup(27'h7FF);
      check("evict idx", 64'(hit_idx_o), 64'd0);
      check("evict pte", pte_o, 64'hBEEF);
      lookup(27'h1000);
      check("evicted miss", 64'(miss_o), 64'd1);
      for (int k = 0; k < ENTRIES; k++) fill(27'h2000 + 27'(k), 64'h100 + 64'(k));
      lookup(27'h2000);
      check("rr first idx", 64'(hit_idx_o), 64'd1);
      lookup(27'h201F);
      check("rr wrap idx", 64'(hit_idx_o), 64'd0);
      fill(27'h3000, 64'h3000);
      lookup(27'h3000);
      check("rr ptr=1 idx", 64'(hit_idx_o), 64'd1);

      // Reset mid-lookup
      flush_all();
      for (int i = 0; i < 5; i++) fill(27'h500 + 27'(i), 64'h50 + 64'(i));
      lookup(27'h502);
      check("prerst hit", 64'(hit_o), 64'd1);
      lookup_valid_i = 1'b1;
      lookup_vpn_i   = 27'h503;
      #2;
      rstn_i = 1'b0;
      #1;
      check("async rst hit", 64'(hit_o), 64'd0);
      check("async rst pte", pte_o, 64'd0);
      @(posedge clk_i);
      #1;
      check("inrst hit", 64'(hit_o), 64'd0);
      check("inrst idx", 64'(hit_idx_o), 64'd0);
      lookup_valid_i = 1'b0;
      #2;
      rstn_i = 1'b1;
      idle();
      check("postrst no result", 64'(hit_o | miss_o), 64'd0);
      for (int i = 0; i < 5; i++) begin
         lookup(27'h500 + 27'(i));
         check("postrst miss", 64'(miss_o), 64'd1);
      end
      check("postrst full", 64'(full_o), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
